// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO onto an 8N1 UART line, LSB first, one pop per frame.
// tx, busy and frame_done are registered; fifo_rd is the only combinational output.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic              fifo_wr,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  // state | meaning
  // IDLE  | line high, pop a byte when the FIFO has one and no write collides
  // LOAD  | one cycle for the FIFO's registered dout to settle, then capture it
  // START | start bit (low) for CLKS_PER_BIT cycles
  // DATA  | eight data bits, LSB first
  // STOP  | stop bit (high); frame_done marks its last cycle

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_TC  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_PRE = CW'(CLKS_PER_BIT - 2);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  state_t            state_q, state_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CW-1:0]     baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              baud_tc;

  assign baud_tc = (baud_q == BAUD_TC);

  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    fifo_rd = 1'b0;
    unique case (state_q)
      IDLE: begin
        // The FIFO ignores a read that coincides with a write, so yield to the producer.
        if (!fifo_empty && !fifo_wr && !rst) begin
          fifo_rd = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        shift_d = fifo_dout;
        tx_d    = 1'b0;
        baud_d  = '0;
        state_d = START;
      end
      START: begin
        if (baud_tc) begin
          baud_d  = '0;
          tx_d    = shift_q[0];
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_tc) begin
          baud_d = '0;
          if (bit_q == LAST_BIT) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        // Registered pulse: set one cycle early so it lands on the last stop cycle.
        done_d = (baud_q == BAUD_PRE);
        if (baud_tc) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two lanes (4 and 2 clocks per bit) fed by a behavioural FIFO,
// with a serial-line decoder checking frames against the producer's write order.
module tb_fifo_uart_tx;
  localparam int CPB0 = 4;
  localparam int CPB1 = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] fifo_empty = 2'b11;
  logic [1:0] fifo_wr = 2'b00;
  logic [1:0] fifo_rd, tx, busy, frame_done;
  logic [7:0] fifo_dout [2] = '{8'h00, 8'h00};
  logic [7:0] wr_data [2] = '{8'h00, 8'h00};

  logic [7:0] fq [2][$];
  logic [7:0] exp_q [2][$];
  int         gap_q [2][$];
  int frame_cnt [2] = '{0, 0};
  int rd_cnt [2] = '{0, 0};
  int rd_cyc [2] = '{0, 0};
  int fd_cnt [2] = '{0, 0};
  int rd_bad = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB0), .DATA_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty[0]), .fifo_wr(fifo_wr[0]),
    .fifo_dout(fifo_dout[0]), .fifo_rd(fifo_rd[0]), .tx(tx[0]), .busy(busy[0]),
    .frame_done(frame_done[0]));

  fifo_uart_tx #(.CLKS_PER_BIT(CPB1), .DATA_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty[1]), .fifo_wr(fifo_wr[1]),
    .fifo_dout(fifo_dout[1]), .fifo_rd(fifo_rd[1]), .tx(tx[1]), .busy(busy[1]),
    .frame_done(frame_done[1]));

  // 16-deep FIFO with write priority and registered read data.
  initial forever begin
    @(posedge clk);
    cyc <= cyc + 1;
    for (int g = 0; g < 2; g++) begin
      if (frame_done[g] === 1'b1) fd_cnt[g]++;
      if (fifo_rd[g] === 1'b1) begin
        rd_cnt[g]++;
        rd_cyc[g] = cyc;
        if (rst || fifo_wr[g] || fq[g].size() == 0) rd_bad++;
      end
      if (fifo_wr[g]) begin
        if (fq[g].size() < 16) fq[g].push_back(wr_data[g]);
      end else if (fifo_rd[g] === 1'b1 && fq[g].size() != 0) begin
        fifo_dout[g] <= fq[g].pop_front();
      end
      fifo_empty[g] <= (fq[g].size() == 0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  // Called at the negedge of the first start-bit cycle.
  task automatic rx_frame(input int g, output bit ab);
    int         cpb;
    logic [9:0] bits;
    bit         hold_ok, fd_ok, busy_ok;
    string      ln;
    cpb = (g == 0) ? CPB0 : CPB1;
    ln = $sformatf("lane%0d", g);
    bits = '0; hold_ok = 1; fd_ok = 1; busy_ok = 1; ab = 0;
    chk({ln, "_rd_to_start_latency"}, 32'(cyc - rd_cyc[g]), 32'd2);
    for (int i = 0; i < 10 * cpb; i++) begin
      if (i > 0) @(negedge clk);
      if (rst) begin
        ab = 1;
        return;
      end
      if (i % cpb == 0) bits[i / cpb] = tx[g];
      else if (tx[g] !== bits[i / cpb]) hold_ok = 0;
      if (frame_done[g] !== (i == 10 * cpb - 1)) fd_ok = 0;
      if (busy[g] !== 1'b1) busy_ok = 0;
    end
    chk({ln, "_start_bit"}, 32'(bits[0]), 32'd0);
    chk({ln, "_stop_bit"}, 32'(bits[9]), 32'd1);
    chk({ln, "_bit_hold"}, 32'(hold_ok), 32'd1);
    chk({ln, "_frame_done_last_cycle_only"}, 32'(fd_ok), 32'd1);
    chk({ln, "_busy_during_frame"}, 32'(busy_ok), 32'd1);
    if (exp_q[g].size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_unexpected_frame: got 0x%0h with no byte outstanding", ln, bits[8:1]);
    end else begin
      chk({ln, "_byte"}, 32'(bits[8:1]), 32'(exp_q[g].pop_front()));
    end
    @(negedge clk);
    if (!rst) chk({ln, "_idle_after_frame_busy_tx"}, 32'({busy[g], tx[g]}), 32'b01);
  endtask

  task automatic mon(input int g);
    int gap = 1000;
    bit ab;
    forever begin
      @(negedge clk);
      if (rst) gap = 0;
      else if (tx[g] === 1'b1) gap++;
      else begin
        gap_q[g].push_back(gap);
        rx_frame(g, ab);
        gap = ab ? 0 : 1;
        if (!ab) frame_cnt[g]++;
      end
    end
  endtask

  task automatic push(input int g, input logic [7:0] b);
    @(negedge clk);
    fifo_wr[g] = 1'b1;
    wr_data[g] = b;
    exp_q[g].push_back(b);
    @(negedge clk);
    fifo_wr[g] = 1'b0;
  endtask

  task automatic wait_frames(input int g, input int n, input int budget);
    int t = 0;
    while (frame_cnt[g] < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("lane%0d_frames_within_budget", g), 32'(frame_cnt[g] >= n), 32'd1);
  endtask

  initial begin
    int n, r, f, t, nw;
    fork
      mon(0);
      mon(1);
    join_none

    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx), 32'b11);
    chk("reset_busy", 32'(busy), 32'b00);
    chk("reset_frame_done", 32'(frame_done), 32'b00);
    chk("reset_fifo_rd", 32'(fifo_rd), 32'b00);
    rst = 1'b0;

    // Single byte 0xA5
    r = rd_cnt[0];
    push(0, 8'hA5);
    wait_frames(0, 1, 100);
    chk("lane0_single_rd_pulse", 32'(rd_cnt[0] - r), 32'd1);

    // Empty FIFO stays quiet
    repeat (100) begin
      @(negedge clk);
      chk("idle_tx_rd_busy", 32'({tx, fifo_rd, busy}), 32'b110000);
    end

    // 16-byte burst filling the FIFO
    gap_q[0].delete();
    n = frame_cnt[0];
    r = rd_cnt[0];
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      fifo_wr[0] = 1'b1;
      wr_data[0] = 8'(i);
      exp_q[0].push_back(8'(i));
    end
    @(negedge clk);
    fifo_wr[0] = 1'b0;
    wait_frames(0, n + 16, 16 * 50 + 100);
    chk("lane0_burst_rd_pulses", 32'(rd_cnt[0] - r), 32'd16);
    chk("lane0_burst_frame_count", 32'(gap_q[0].size()), 32'd16);
    for (int i = 1; i < gap_q[0].size(); i++) chk("lane0_burst_gap", 32'(gap_q[0][i]), 32'd2);
    @(negedge clk);
    chk("lane0_burst_end_empty_busy", 32'({fifo_empty[0], busy[0]}), 32'b10);

    // Producer writes hold off the read
    n = frame_cnt[0];
    @(negedge clk);
    fifo_wr[0] = 1'b1;
    wr_data[0] = 8'hC1;
    exp_q[0].push_back(8'hC1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr_data[0] = 8'hC2 + 8'(i);
      exp_q[0].push_back(8'hC2 + 8'(i));
      #1 chk("lane0_rd_gated_by_wr", 32'(fifo_rd[0]), 32'd0);
    end
    @(negedge clk);
    fifo_wr[0] = 1'b0;
    #1 chk("lane0_rd_after_wr_drops", 32'(fifo_rd[0]), 32'd1);
    wait_frames(0, n + 4, 4 * 60);

    // Reset during data bit 3 of 0x3C, 0x5A queued behind it
    f = fd_cnt[0];
    push(0, 8'h3C);
    t = 0;
    while (tx[0] !== 1'b0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("lane0_3c_start_seen", 32'(tx[0]), 32'd0);
    fifo_wr[0] = 1'b1;
    wr_data[0] = 8'h5A;
    exp_q[0].push_back(8'h5A);
    @(negedge clk);
    fifo_wr[0] = 1'b0;
    repeat (4 * CPB0) @(negedge clk);
    rst = 1'b1;
    void'(exp_q[0].pop_front());
    n = frame_cnt[0];
    @(negedge clk);
    chk("lane0_abort_tx_busy_done", 32'({tx[0], busy[0], frame_done[0]}), 32'b100);
    @(negedge clk);
    rst = 1'b0;
    wait_frames(0, n + 1, 100);
    chk("lane0_abort_frame_done_pulses", 32'(fd_cnt[0] - f), 32'd1);

    // Randomised producer on the 2-clock lane
    n = frame_cnt[1];
    r = rd_cnt[1];
    nw = 0;
    repeat (400) begin
      @(negedge clk);
      fifo_wr[1] = 1'b0;
      if ($urandom_range(0, 9) == 0 && fq[1].size() < 16) begin
        fifo_wr[1] = 1'b1;
        wr_data[1] = 8'($urandom);
        exp_q[1].push_back(wr_data[1]);
        nw++;
      end
    end
    @(negedge clk);
    fifo_wr[1] = 1'b0;
    wait_frames(1, n + nw, nw * 30 + 100);
    chk("lane1_stress_all_sent", 32'(exp_q[1].size()), 32'd0);
    chk("lane1_stress_rd_pulses", 32'(rd_cnt[1] - r), 32'(nw));

    repeat (5) @(negedge clk);
    chk("rd_while_illegal", 32'(rd_bad), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Downstream drain stage for the 16-deep, 8-bit synchronous FIFO.
- Pops one byte at a time using the FIFO's empty/rd/dout interface and serialises it onto an 8N1 UART line, LSB first.
- Sits between the FIFO and the chip's serial TX pin, running continuously while data is present.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; legal range 2..65535
DATA_W, 8, byte width; fixed at 8 to match the FIFO

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
fifo_empty  input  1  FIFO empty flag
fifo_wr  input  1  tap of the producer's FIFO write strobe, same cycle
fifo_dout  input  8  FIFO registered read data
fifo_rd  output  1  FIFO read strobe (combinational)
tx  output  1  serial line, idle high
busy  output  1  high in any state other than IDLE
frame_done  output  1  one-cycle pulse in the last cycle of each stop bit

Behaviour:
- Reset: clk and rst are the only clock and reset; rst is synchronous, active-high, sampled on the rising edge of clk.
  - Reset values: state=IDLE, tx=1, busy=0, frame_done=0, fifo_rd=0, baud_cnt=0, bit_idx=0, shift_reg=0.
- Reset mid-frame:
  - Abort the frame; tx returns to 1 at the reset edge.
  - A byte already popped is lost.
  - No rd is issued while rst=1.
- States: IDLE, LOAD, START, DATA, STOP.
- IDLE:
  - fifo_rd = !fifo_empty && !fifo_wr (combinational, IDLE only).
  - fifo_wr gating is required because the FIFO gives write priority and would silently ignore a simultaneous read.
  - If fifo_rd=1, go to LOAD at the next edge; otherwise stay.
- LOAD: exactly 1 cycle.
  - fifo_dout is valid here because the FIFO registers dout on the rd edge.
  - At the end edge: shift_reg<=fifo_dout, tx<=0, baud_cnt<=0, go to START.
- START:
  - tx=0 for CLKS_PER_BIT cycles.
  - At baud_cnt==CLKS_PER_BIT-1: baud_cnt<=0, tx<=shift_reg[0], bit_idx<=0, go to DATA.
- DATA:
  - Each bit is held for CLKS_PER_BIT cycles.
  - On each bit boundary, shift_reg is shifted right and tx<=next bit.
  - After bit_idx==7 completes: tx<=1, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - frame_done=1 in the final STOP cycle; then go to IDLE.
- Timing:
  - Frame length on tx: 10*CLKS_PER_BIT cycles, from start-bit falling edge to end of stop bit.
  - Latency: rd-asserted cycle N gives tx falling at edge N+2 (rd edge, then LOAD edge).
  - Back-to-back frames: minimum tx-high gap between stop-bit end and next start bit = 2 cycles (IDLE + LOAD).
- Counter widths:
  - baud_cnt width = $clog2(CLKS_PER_BIT); no wrap except the explicit reset to 0 at the terminal count.
  - bit_idx is 3 bits.
- fifo_rd is never asserted outside IDLE, so exactly one pop occurs per frame.
- fifo_empty/fifo_wr changes outside IDLE have no effect.
- tx is registered (glitch-free); fifo_rd is the only combinational output.

Test Plan:
- CLKS_PER_BIT=4, reset, then one byte 0xA5 in FIFO:
  - fifo_rd pulses exactly 1 cycle.
  - tx reads 0 | 1,0,1,0,0,1,0,1 | 1, each value held 4 cycles (40 cycles total).
  - frame_done pulses once in cycle 40; busy then falls.
- Push 16 bytes 0x00..0x0F (FIFO full), then stop writing:
  - 16 frames decoded in order 0x00..0x0F.
  - Exactly 16 rd pulses.
  - tx-high gap between frames = 2 cycles.
  - fifo_empty=1 and busy=0 at the end.
- FIFO non-empty with fifo_wr=1 held for 3 cycles in IDLE:
  - fifo_rd stays 0 for those 3 cycles.
  - fifo_rd asserts in the first cycle fifo_wr=0; the byte is transmitted correctly.
- Empty FIFO for 100 cycles:
  - tx=1, fifo_rd=0, busy=0 throughout.
- rst asserted during data bit 3 of 0x3C:
  - tx=1 and busy=0 at the reset edge.
  - No frame_done pulse.
  - After release, the next FIFO byte 0x5A is sent intact.
- CLKS_PER_BIT=2 stress with random bytes and random producer writes:
  - Scoreboard shows serial output = FIFO write order.
  - No byte is lost or duplicated.
